// File: rtl/glb_pkg.sv
// glb_pkg: shared encodings for the glb_acc partial-sum buffer.
package glb_pkg;

   // Request opcodes carried on w_op
   typedef enum logic [1:0] {
      GLB_OP_READ  = 2'b00,
      GLB_OP_WRITE = 2'b01,
      GLB_OP_ACCUM = 2'b10,
      GLB_OP_RSVD  = 2'b11
   } glb_op_e;

   // Buffer controller states
   typedef enum logic {
      GLB_ST_IDLE  = 1'b0,
      GLB_ST_CLEAR = 1'b1
   } glb_state_e;

endpackage

// File: rtl/glb_sat_add.sv
// glb_sat_add: combinational signed DATA_W adder with overflow detect.
// Optional macro GLB_ACC_SAT_EN: clamp the sum to the signed range on overflow;
// otherwise the wrapped two's-complement sum is returned.
module glb_sat_add #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] sum_o,
   output logic              ovf_o
);

   logic [DATA_W-1:0] raw;

   assign raw = a_i + b_i;

   // Overflow: operands agree in sign but the result does not
   assign ovf_o = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (raw[DATA_W-1] != a_i[DATA_W-1]);

`ifdef GLB_ACC_SAT_EN
   localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

   // Negative operands can only overflow towards the minimum, and vice versa
   always_comb begin
      sum_o = raw;
      if (ovf_o) sum_o = a_i[DATA_W-1] ? SMIN : SMAX;
   end
`else
   assign sum_o = raw;
`endif

endmodule

// File: rtl/glb_acc.sv
// glb_acc: global buffer for PE-array partial sums. Read / write / signed
// accumulate over a valid/ready port, registered reads, and a DEPTH-cycle
// clear sweep run after reset or on w_clear.
// Optional macro GLB_ACC_SAT_EN selects saturating accumulate (see glb_sat_add).
module glb_acc
   import glb_pkg::*;
#(
   parameter  int DATA_W = 16,
   parameter  int DEPTH  = 64,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              w_clk,
   input  logic              w_rst,
   input  logic              w_req_valid,
   output logic              r_req_ready,
   input  logic [1:0]        w_op,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data_in,
   output logic              r_rd_valid,
   output logic [DATA_W-1:0] r_rd_data,
   input  logic              w_clear,
   output logic              r_busy,
   output logic              r_acc_ovf
);

   logic [DATA_W-1:0] mem [DEPTH];

   glb_state_e        state_q;
   logic [ADDR_W-1:0] clr_ptr_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              acc_ovf_q;

   glb_op_e           op;
   logic              accept;
   logic              is_read;
   logic              is_accum;
   logic              wr_en;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] acc_sum;
   logic              acc_ovf;
   logic [DATA_W-1:0] wr_data;

   assign op          = glb_op_e'(w_op);
   assign r_req_ready = (state_q == GLB_ST_IDLE) && !w_clear;
   assign accept      = w_req_valid && r_req_ready;
   assign is_read     = accept && (op == GLB_OP_READ);
   assign is_accum    = accept && (op == GLB_OP_ACCUM);
   assign wr_en       = accept && ((op == GLB_OP_WRITE) || (op == GLB_OP_ACCUM));

   // Combinational read port feeds both the read register and the accumulator,
   // so back-to-back ACCUMs see the value written on the previous edge.
   assign rd_word = mem[w_addr];

   glb_sat_add #(.DATA_W(DATA_W)) u_add (
      .a_i   (rd_word),
      .b_i   (w_data_in),
      .sum_o (acc_sum),
      .ovf_o (acc_ovf)
   );

   assign wr_data = (op == GLB_OP_ACCUM) ? acc_sum : w_data_in;

   // Storage: zeroed one word per cycle by the sweep, otherwise request writes.
   // Writes are suppressed while reset is asserted.
   always_ff @(posedge w_clk) begin
      if (!w_rst) begin
         if (state_q == GLB_ST_CLEAR) mem[clr_ptr_q] <= '0;
         else if (wr_en)              mem[w_addr]    <= wr_data;
      end
   end

   // Controller FSM plus registered read strobe/data and sticky overflow
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state_q    <= GLB_ST_CLEAR;
         clr_ptr_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         acc_ovf_q  <= 1'b0;
      end else begin
         rd_valid_q <= is_read;
         if (is_read) rd_data_q <= rd_word;
         case (state_q)
            GLB_ST_IDLE: begin
               if (w_clear) begin
                  state_q   <= GLB_ST_CLEAR;
                  clr_ptr_q <= '0;
                  acc_ovf_q <= 1'b0;
               end else if (is_accum && acc_ovf) begin
                  acc_ovf_q <= 1'b1;
               end
            end
            GLB_ST_CLEAR: begin
               clr_ptr_q <= clr_ptr_q + 1'b1;
               if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_q <= GLB_ST_IDLE;
            end
            default: state_q <= GLB_ST_IDLE;
         endcase
      end
   end

   assign r_busy     = (state_q == GLB_ST_CLEAR);
   assign r_rd_valid = rd_valid_q;
   assign r_rd_data  = rd_data_q;
   assign r_acc_ovf  = acc_ovf_q;

endmodule

// File: tb/tb_glb_acc.sv
// tb_glb_acc: directed scoreboard bench for glb_acc (DATA_W=16, DEPTH=64).
// Read expectations are queued at issue time and popped by a negedge monitor.
module tb_glb_acc;

   localparam int DW = 16;
   localparam int AW = 6;

   logic          w_clk = 1'b0;
   logic          w_rst;
   logic          w_req_valid;
   logic          r_req_ready;
   logic [1:0]    w_op;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data_in;
   logic          r_rd_valid;
   logic [DW-1:0] r_rd_data;
   logic          w_clear;
   logic          r_busy;
   logic          r_acc_ovf;

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] exp_q [$];

   glb_acc #(.DATA_W(DW), .DEPTH(64)) dut (
      .w_clk       (w_clk),
      .w_rst       (w_rst),
      .w_req_valid (w_req_valid),
      .r_req_ready (r_req_ready),
      .w_op        (w_op),
      .w_addr      (w_addr),
      .w_data_in   (w_data_in),
      .r_rd_valid  (r_rd_valid),
      .r_rd_data   (r_rd_data),
      .w_clear     (w_clear),
      .r_busy      (r_busy),
      .r_acc_ovf   (r_acc_ovf)
   );

   always #5 w_clk = ~w_clk;

   // Monitor: every read strobe must match the oldest queued expectation
   always @(negedge w_clk) begin
      if (r_rd_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: got strobe data=%h, required no strobe", r_rd_data);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (r_rd_data !== e) begin
               errors++;
               $display("FAIL rd_data: got %h required %h", r_rd_data, e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // One accepted request; caller guarantees ready is high
   task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
      w_req_valid = 1'b1;
      w_op        = op;
      w_addr      = a;
      w_data_in   = d;
      @(posedge w_clk); #1;
      w_req_valid = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
      exp_q.push_back(e);
      issue(2'b00, a, '0);
   endtask

   // Count cycles until busy drops, checking ready stays low meanwhile
   task automatic sweep_len(input string name, output int n);
      logic ready_seen;
      n = 0;
      ready_seen = 1'b0;
      while (r_busy === 1'b1 && n < 200) begin
         if (r_req_ready !== 1'b0) ready_seen = 1'b1;
         @(posedge w_clk); #1;
         n++;
      end
      chk({name, "_len"}, n, 64);
      chk({name, "_rdy_low"}, ready_seen, 0);
      chk({name, "_rdy_after"}, r_req_ready, 1);
   endtask

   initial begin
      int n;
      w_rst = 1'b1; w_req_valid = 1'b0; w_op = 2'b00; w_addr = '0;
      w_data_in = '0; w_clear = 1'b0;

      // 1: reset, full sweep, read of a cleared word
      repeat (2) @(posedge w_clk);
      #1 w_rst = 1'b0;
      chk("rst_busy", r_busy, 1);
      chk("rst_valid", r_rd_valid, 0);
      chk("rst_ovf", r_acc_ovf, 0);
      sweep_len("rst_sweep", n);
      rd(6'd5, 16'h0000);

      // 2: write then read next cycle
      issue(2'b01, 6'd1, 16'h5555);
      issue(2'b01, 6'd3, 16'h1234);
      rd(6'd3, 16'h1234);
      rd(6'd1, 16'h5555);

      // 3: chained accumulates, negative operand
      issue(2'b01, 6'd7, 16'd100);
      issue(2'b10, 6'd7, 16'd25);
      issue(2'b10, 6'd7, 16'd25);
      rd(6'd7, 16'd150);
      issue(2'b10, 6'd7, 16'hFFD8);    // -40
      issue(2'b11, 6'd7, 16'h7777);    // reserved: no effect
      rd(6'd7, 16'd110);
      chk("acc_ovf_clear", r_acc_ovf, 0);

      // 4: positive overflow
      issue(2'b01, 6'd9, 16'h7FF0);
      issue(2'b10, 6'd9, 16'h0020);
`ifdef GLB_ACC_SAT_EN
      rd(6'd9, 16'h7FFF);
`else
      rd(6'd9, 16'h8010);
`endif
      chk("ovf_set", r_acc_ovf, 1);
      rd(6'd7, 16'd110);
      chk("ovf_sticky", r_acc_ovf, 1);

      // 5: clear collides with a write; clear wins
      w_clear = 1'b1;
      w_req_valid = 1'b1; w_op = 2'b01; w_addr = 6'd1; w_data_in = 16'hAAAA;
      #1 chk("clr_rdy_low", r_req_ready, 0);
      @(posedge w_clk); #1;
      w_clear = 1'b0; w_req_valid = 1'b0;
      chk("clr_busy", r_busy, 1);
      chk("clr_ovf", r_acc_ovf, 0);
      sweep_len("clr_sweep", n);
      rd(6'd1, 16'h0000);
      rd(6'd7, 16'h0000);
      rd(6'd9, 16'h0000);

      // 6: reset mid-sweep restarts it; a held request waits for idle
      issue(2'b01, 6'd4, 16'h0BEE);
      rd(6'd4, 16'h0BEE);
      w_clear = 1'b1;
      @(posedge w_clk); #1;
      w_clear = 1'b0;
      repeat (20) @(posedge w_clk);
      #1 w_rst = 1'b1;
      @(posedge w_clk); #1;
      w_rst = 1'b0;
      w_req_valid = 1'b1; w_op = 2'b00; w_addr = 6'd4; w_data_in = '0;
      exp_q.push_back(16'h0000);
      n = 0;
      while (r_req_ready !== 1'b1 && n < 200) begin
         if (r_busy !== 1'b1) begin
            errors++; checks++;
            $display("FAIL restart_busy: got busy=%b at cycle %0d, required 1", r_busy, n);
         end
         @(posedge w_clk); #1;
         n++;
      end
      chk("restart_len", n, 64);
      chk("restart_busy_low", r_busy, 0);
      @(posedge w_clk); #1;
      w_req_valid = 1'b0;

      repeat (4) @(posedge w_clk);
      #1 chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
